mux_nx1_pipe: RTL and testbench

MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/mux_nx1_pipe.sv | 85 ++++++++
 tb/tb_mux_nx1_pipe.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the N:1 pipelined mux: mode encodings and the
// select-width helper used to size channel indices.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel index width; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Cyclic priority search: grants the first requester after ptr, wrapping
// from N-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        // k = N revisits ptr itself, so a lone requester at ptr still wins.
        for (int k = 1; k <= N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N:1 data mux with fixed-select or round-robin channel choice feeding a
// single-entry registered output stage with valid/ready handshake.
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0]    ptr;
    logic [CHANNELS-1:0] rr_grant;
    logic [SEL_W-1:0]    rr_idx;
    logic                rr_any;
    logic [CHANNELS-1:0] fix_grant;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    src_idx;
    logic                grant_any;
    logic                load_en;

    rr_arbiter #(
        .N     (CHANNELS),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // Out-of-range select values grant nothing.
    always_comb begin
        fix_grant = '0;
        if (int'(sel) < CHANNELS) begin
            if (in_valid[sel]) fix_grant[sel] = 1'b1;
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant     = rr_grant;
            src_idx   = rr_idx;
            grant_any = rr_any;
        end else begin
            grant     = fix_grant;
            src_idx   = sel;
            grant_any = |fix_grant;
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign in_ready = (rst || !load_en) ? '0 : grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SEL_W'(CHANNELS - 1);
        end else if (load_en) begin
            if (grant_any) begin
                out_data  <= in_data[int'(src_idx)*WIDTH +: WIDTH];
                out_chan  <= src_idx;
                out_valid <= 1'b1;
                if (mode == MODE_RR) ptr <= src_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: a 4-channel instance for the main
// behaviour and a 5-channel instance to reach an out-of-range select.
module tb_mux_nx1_pipe;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid, out_ready;

    // 5-channel instance
    logic [39:0] b_in_data;
    logic [4:0]  b_in_valid, b_in_ready;
    logic        b_mode;
    logic [2:0]  b_sel;
    logic [7:0]  b_out_data;
    logic [2:0]  b_out_chan;
    logic        b_out_valid, b_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mux_nx1_pipe #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nx1_pipe #(.WIDTH(8), .CHANNELS(5)) dut5 (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
        .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_d [4];
    logic [3:0] exp_rdy;

    initial begin
        exp_d = '{8'h11, 8'h22, 8'hA5, 8'h44};
        rst = 1'b1;
        in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        in_valid = 4'b1111; mode = MODE_FIXED; sel = 2'd0; out_ready = 1'b1;
        b_in_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        b_in_valid = 5'b11111; b_mode = MODE_FIXED; b_sel = 3'd4; b_out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  {24'd0, out_data},  32'd0);
        chk("rst_chan",  {30'd0, out_chan},  32'd0);
        chk("rst_ready", {28'd0, in_ready},  32'd0);

        // Fixed select of channel 2
        rst = 1'b0; sel = 2'd2;
        #1 chk("fix_ready", {28'd0, in_ready}, 32'h4);
        tick();
        chk("fix_data",  {24'd0, out_data},  32'hA5);
        chk("fix_chan",  {30'd0, out_chan},  32'd2);
        chk("fix_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 4'b0000;
        tick();
        chk("idle_drop", {31'd0, out_valid}, 32'd0);

        // Round-robin from reset pointer (fixed transfer must not move it)
        mode = MODE_RR; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_rdy = 4'b0001 << (i % 4);
            #1 chk("rr_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
            tick();
            chk("rr_chan",  {30'd0, out_chan},  32'(i % 4));
            chk("rr_data",  {24'd0, out_data},  {24'd0, exp_d[i % 4]});
            chk("rr_valid", {31'd0, out_valid}, 32'd1);
        end

        // Sparse requesters with wrap: pointer now at 0
        in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_wrap", {30'd0, out_chan}, (i == 1) ? 32'd0 : 32'd3);
        end

        // Backpressure hold, then same-cycle replacement
        mode = MODE_FIXED; sel = 2'd1; in_valid = 4'b0010;
        in_data[15:8] = 8'h3C;
        tick();
        chk("bp_load", {24'd0, out_data}, 32'h3C);
        out_ready = 1'b0; in_data[15:8] = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", {28'd0, in_ready}, 32'd0);
            tick();
            chk("bp_hold",  {24'd0, out_data},  32'h3C);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release", {28'd0, in_ready}, 32'h2);
        tick();
        chk("bp_replace", {24'd0, out_data},  32'h77);
        chk("bp_rvalid",  {31'd0, out_valid}, 32'd1);

        // Reset while a word is held
        out_ready = 1'b0; mode = MODE_RR; in_valid = 4'b1111; rst = 1'b1;
        #1 chk("rst_mid_ready", {28'd0, in_ready}, 32'd0);
        tick();
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_data",  {24'd0, out_data},  32'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick();
        chk("rst_rr_chan", {30'd0, out_chan}, 32'd0);
        chk("rst_rr_data", {24'd0, out_data}, 32'h11);

        // Out-of-range select on the 5-channel instance
        b_sel = 3'd4;
        tick();
        chk("b_sel4_chan", {29'd0, b_out_chan}, 32'd4);
        chk("b_sel4_data", {24'd0, b_out_data}, 32'h55);
        b_sel = 3'd5;
        #1 chk("b_sel5_ready", {27'd0, b_in_ready}, 32'd0);
        tick();
        chk("b_sel5_drop", {31'd0, b_out_valid}, 32'd0);
        b_sel = 3'd7;
        tick();
        chk("b_sel7_ready", {27'd0, b_in_ready}, 32'd0);
        chk("b_sel7_valid", {31'd0, b_out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
